hilo_divider: RTL and testbench

- Multi-cycle unsigned divider that owns the HI/LO register pair and supplies HiOut/LoOut to the result multiplexer.
- Started by function code DIVU (6'b011011).
- Restoring shift-subtract, one quotient bit per clock. When finished, HI = remainder and LO = quotient.
- MFHI/MFLO reads are pure reads of the held registers in the result path; this block does not act on them.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/div_step.sv | 29 ++
 rtl/hilo_divider.sv | 124 ++++++++++++
 tb/tb_hilo_divider.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, divider state encoding, default datapath width.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 32;

  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_DIVU = 6'b011011;
  localparam logic [5:0] FN_MFHI = 6'b010000;
  localparam logic [5:0] FN_MFLO = 6'b010010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract division step; purely combinational.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Extra MSB holds the bit shifted out of rem so the compare never overflows.
  assign shifted = {rem_i, quo_i[WIDTH-1]};
  assign diff    = shifted - {1'b0, divisor_i};

  always_comb begin
    if (shifted >= {1'b0, divisor_i}) begin
      rem_o = diff[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/hilo_divider.sv
// Multi-cycle unsigned divider owning HI (remainder) / LO (quotient).
// Optional divide-by-zero flag output dz enabled by macro DIV_ZERO_FLAG_EN.
module hilo_divider
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = ALU_WIDTH,
  parameter int unsigned CNT_W     = 6,
  parameter logic [5:0]  DIVU_CODE = FN_DIVU
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut,
  output logic             busy,
`ifdef DIV_ZERO_FLAG_EN
  output logic             dz,
`endif
  output logic             done
);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] step_rem, step_quo;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    div_d   = div_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (Signal == DIVU_CODE) begin
          state_d = RUN;
          busy_d  = 1'b1;
          rem_d   = '0;
          quo_d   = dataA;
          div_d   = dataB;
          cnt_d   = '0;
        end
      end
      RUN: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = DONE;
      end
      DONE: begin
        hi_d    = rem_q;
        lo_d    = quo_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      div_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      div_q   <= div_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef DIV_ZERO_FLAG_EN
  logic dz_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      dz_q <= 1'b0;
    end else if (state_q == IDLE && Signal == DIVU_CODE) begin
      dz_q <= (dataB == '0);
    end
  end

  assign dz = dz_q;
`endif

  assign HiOut = hi_q;
  assign LoOut = lo_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_hilo_divider.sv
// Directed self-checking bench for hilo_divider; honours DIV_ZERO_FLAG_EN when defined.
module tb_hilo_divider;
  import alu_pkg::*;

  localparam int unsigned W = 32;

  logic         clk;
  logic         reset;
  logic [W-1:0] dataA;
  logic [W-1:0] dataB;
  logic [5:0]   Signal;
  logic [W-1:0] HiOut;
  logic [W-1:0] LoOut;
  logic         busy;
  logic         done;
`ifdef DIV_ZERO_FLAG_EN
  logic         dz;
`endif

  int unsigned n_checks;
  int unsigned n_fail;

  hilo_divider #(.WIDTH(W), .CNT_W(6), .DIVU_CODE(FN_DIVU)) dut (
    .clk    (clk),
    .reset  (reset),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .HiOut  (HiOut),
    .LoOut  (LoOut),
    .busy   (busy),
`ifdef DIV_ZERO_FLAG_EN
    .dz     (dz),
`endif
    .done   (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue DIVU at a negedge; returns at the negedge after the accepting edge with Signal cleared.
  task automatic start_div(input logic [W-1:0] a, input logic [W-1:0] b);
    Signal = FN_DIVU;
    dataA  = a;
    dataB  = b;
    @(posedge clk);
    @(negedge clk);
    Signal = FN_MFLO;
  endtask

  // Counts edges after acceptance until done is seen at a negedge; bounded.
  task automatic wait_done(output int unsigned cycles);
    cycles = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if (done) return;
    end
    cycles = 999;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    Signal = FN_ADD;
    dataA  = '0;
    dataB  = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (HiOut !== '0 || LoOut !== '0 || busy !== 1'b0 || done !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: Hi=%h Lo=%h busy=%b done=%b, required all 0", i, HiOut, LoOut, busy, done);
      end
    end
`ifdef DIV_ZERO_FLAG_EN
    n_checks++;
    if (dz !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b required 0", dz); end
`endif
  endtask

  task automatic test_basic();
    int unsigned cyc;
    start_div(32'd100, 32'd7);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b required 1", busy); end
    n_checks++;
    if (HiOut !== '0 || LoOut !== '0) begin
      n_fail++; $display("FAIL basic_no_partial: Hi=%h Lo=%h required 0/0", HiOut, LoOut);
    end
    wait_done(cyc);
    n_checks++;
    if (cyc !== 33) begin n_fail++; $display("FAIL basic_latency: got %0d required 33", cyc); end
    n_checks++;
    if (LoOut !== 32'd14 || HiOut !== 32'd2) begin
      n_fail++; $display("FAIL basic_result: Lo=%0d Hi=%0d required 14/2", LoOut, HiOut);
    end
    Signal = FN_MFHI;
    @(negedge clk);
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL basic_done_pulse: done=%b busy=%b required 0/0", done, busy);
    end
    for (int i = 0; i < 3; i++) @(negedge clk);
    n_checks++;
    if (LoOut !== 32'd14 || HiOut !== 32'd2) begin
      n_fail++; $display("FAIL basic_hold: Lo=%0d Hi=%0d required 14/2", LoOut, HiOut);
    end
  endtask

  task automatic test_busy_ignore();
    int unsigned cyc;
    start_div(32'hFFFF_FFFF, 32'd1);
    for (int i = 0; i < 10; i++) @(negedge clk);
    Signal = FN_DIVU;
    dataA  = 32'd9;
    dataB  = 32'd3;
    @(negedge clk);
    Signal = FN_ADD;
    dataA  = 32'd1234;
    dataB  = 32'd5;
    wait_done(cyc);
    n_checks++;
    if (cyc !== 22) begin n_fail++; $display("FAIL ignore_latency: got %0d required 22", cyc); end
    n_checks++;
    if (LoOut !== 32'hFFFF_FFFF || HiOut !== 32'd0) begin
      n_fail++; $display("FAIL ignore_result: Lo=%h Hi=%h required ffffffff/0", LoOut, HiOut);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin
        n_checks++; n_fail++;
        $display("FAIL ignore_no_restart: got done=1 required 0");
      end
    end
  endtask

  task automatic test_div_zero();
    int unsigned cyc;
    start_div(32'd5, 32'd0);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 33) begin n_fail++; $display("FAIL dz_latency: got %0d required 33", cyc); end
    n_checks++;
    if (LoOut !== 32'hFFFF_FFFF || HiOut !== 32'd5) begin
      n_fail++; $display("FAIL dz_result: Lo=%h Hi=%0d required ffffffff/5", LoOut, HiOut);
    end
`ifdef DIV_ZERO_FLAG_EN
    n_checks++;
    if (dz !== 1'b1) begin n_fail++; $display("FAIL dz_flag: got %b required 1", dz); end
`endif
  endtask

  task automatic test_back_to_back();
    int unsigned cyc;
    start_div(32'd3, 32'd10);
    wait_done(cyc);
    n_checks++;
    if (LoOut !== 32'd0 || HiOut !== 32'd3) begin
      n_fail++; $display("FAIL b2b_first: Lo=%0d Hi=%0d required 0/3", LoOut, HiOut);
    end
`ifdef DIV_ZERO_FLAG_EN
    n_checks++;
    if (dz !== 1'b0) begin n_fail++; $display("FAIL b2b_dz: got %b required 0", dz); end
`endif
    start_div(32'd1000, 32'd10);
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: busy=%b required 1", busy); end
    wait_done(cyc);
    n_checks++;
    if (cyc !== 33) begin n_fail++; $display("FAIL b2b_latency: got %0d required 33", cyc); end
    n_checks++;
    if (LoOut !== 32'd100 || HiOut !== 32'd0) begin
      n_fail++; $display("FAIL b2b_second: Lo=%0d Hi=%0d required 100/0", LoOut, HiOut);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int unsigned cyc;
    start_div(32'd50, 32'd5);
    for (int i = 0; i < 19; i++) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_checks++;
    if (HiOut !== '0 || LoOut !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_reset: Hi=%h Lo=%h busy=%b done=%b required all 0", HiOut, LoOut, busy, done);
    end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) begin
        n_checks++; n_fail++;
        $display("FAIL abort_quiet: done=%b busy=%b required 0/0", done, busy);
      end
    end
    start_div(32'd50, 32'd5);
    wait_done(cyc);
    n_checks++;
    if (cyc !== 33 || LoOut !== 32'd10 || HiOut !== 32'd0) begin
      n_fail++; $display("FAIL abort_rerun: cyc=%0d Lo=%0d Hi=%0d required 33/10/0", cyc, LoOut, HiOut);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    Signal   = FN_ADD;
    dataA    = '0;
    dataB    = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_busy_ignore();
    test_div_zero();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
